// File: rtl/mem_stage_pkg.sv
// Shared types for the memory-access stage: memory op encoding, stage packets,
// error codes, FSM state constants and small op-decoding helpers.
package mem_stage_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    LB       = 4'd1,
    LH       = 4'd2,
    LW       = 4'd3,
    LBU      = 4'd4,
    LHU      = 4'd5,
    SB       = 4'd6,
    SH       = 4'd7,
    SW       = 4'd8
  } mem_op_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_BUS      = 2'd2
  } err_code_t;

  // Access FSM states.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst32;
    logic        inst_valid;
    logic [31:0] aux;
    logic [4:0]  dest_reg;
    logic [31:0] res;        // effective address or ALU result
    mem_op_t     mem_op;
    logic [31:0] store_data;
  } ex2mem_pkt_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst32;
    logic        inst_valid;
    logic [4:0]  dest_reg;
    logic [31:0] wb_data;
    err_code_t   err;
  } mem2wb_pkt_t;

  function automatic logic is_store_op(mem_op_t op);
    return op inside {SB, SH, SW};
  endfunction

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic addr_misaligned(mem_op_t op, logic [1:0] off);
    case (op)
      LH, LHU, SH: return off[0];
      LW, SW:      return off != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Selects the addressed byte/halfword lane of a load response and applies
// sign or zero extension according to the load type.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  mem_op_t     mem_op,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = 8'(rdata >> {offset, 3'b000});
  assign half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

  // Extend the selected lane to 32 bits.
  always_comb begin
    // NOTE: default assignment first so no path leaves data unassigned (no latch).
    data = rdata;
    case (mem_op)
      LB:      data = {{24{byte_sel[7]}}, byte_sel};
      LBU:     data = {24'h0, byte_sel};
      LH:      data = {{16{half_sel[15]}}, half_sel};
      LHU:     data = {16'h0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the execute packet, runs at most one
// req/gnt/rvalid data access per instruction, aligns load data and presents
// a writeback packet. Stalls upstream while an access is outstanding.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  ex2mem_pkt_t ex2mem_i,
  output logic        stall_o,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        misalign_o,
  output mem2wb_pkt_t mem2wb_o
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  ex2mem_pkt_t ex_q;
  logic [1:0]  state_q;
  logic [7:0]  cnt_q;
  logic [31:0] rdata_q;
  logic        bus_err_q;

  logic        mem_access;
  logic        misaligned;
  logic        access_ok;
  logic        is_store;
  logic [31:0] load_data;
  logic        unused_aux;

  assign mem_access = ex_q.inst_valid && (ex_q.mem_op != MEM_NONE);
  assign misaligned = mem_access && addr_misaligned(ex_q.mem_op, ex_q.res[1:0]);
  assign access_ok  = mem_access && !misaligned;
  assign is_store   = is_store_op(ex_q.mem_op);
  assign stall_o    = access_ok && (state_q != ST_DONE);
  assign misalign_o = misaligned;
  assign unused_aux = ^ex_q.aux;

  // Pipeline register: advances only when neither we nor downstream stall.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments for all clocked state to avoid ordering races.
    if (rst)                      ex_q <= '0;
    else if (!stall_i && !stall_o) ex_q <= ex2mem_i;
  end

  // Access FSM: request in IDLE, wait for response or timeout, hold in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      rdata_q   <= 32'h0;
      bus_err_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (access_ok && dmem_gnt) begin
          state_q   <= ST_WAIT;
          cnt_q     <= 8'd0;
          bus_err_q <= 1'b0;
        end
        ST_WAIT: begin
          cnt_q <= cnt_q + 8'd1;
          if (dmem_rvalid) begin
            state_q <= ST_DONE;
            rdata_q <= dmem_rdata;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_q   <= ST_DONE;
            rdata_q   <= 32'h0;
            bus_err_q <= 1'b1;
          end
        end
        ST_DONE: if (!stall_i) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dmem_req  = access_ok && (state_q == ST_IDLE);
  assign dmem_we   = is_store;
  assign dmem_addr = {ex_q.res[31:2], 2'b00};

  // Byte enables and lane-replicated store data by access size.
  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = ex_q.store_data;
    case (ex_q.mem_op)
      LB, LBU, SB: begin
        dmem_be    = 4'b0001 << ex_q.res[1:0];
        dmem_wdata = {4{ex_q.store_data[7:0]}};
      end
      LH, LHU, SH: begin
        dmem_be    = ex_q.res[1] ? 4'b1100 : 4'b0011;
        dmem_wdata = {2{ex_q.store_data[15:0]}};
      end
      default: ;
    endcase
  end

  mem_load_align u_load_align (
    .rdata  (rdata_q),
    .offset (ex_q.res[1:0]),
    .mem_op (ex_q.mem_op),
    .data   (load_data)
  );

  // Writeback packet: bubble while stalled, otherwise the resident result.
  always_comb begin
    mem2wb_o = '0;
    if (!stall_o) begin
      mem2wb_o.pc         = ex_q.pc;
      mem2wb_o.inst32     = ex_q.inst32;
      mem2wb_o.inst_valid = ex_q.inst_valid;
      mem2wb_o.dest_reg   = ex_q.dest_reg;
      mem2wb_o.wb_data    = ex_q.res;
      if (misaligned) begin
        mem2wb_o.err      = ERR_MISALIGN;
        mem2wb_o.dest_reg = 5'd0;
      end else if (access_ok) begin
        // Here the FSM is in DONE, so rdata_q/bus_err_q belong to this access.
        if (is_store) mem2wb_o.dest_reg = 5'd0;
        else          mem2wb_o.wb_data  = load_data;
        if (bus_err_q) begin
          mem2wb_o.err      = ERR_BUS;
          mem2wb_o.dest_reg = 5'd0;
        end
      end
    end
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage sitting directly downstream of the execute stage. It registers the execute-stage packet, performs at most one data-memory load or store per instruction over a req/gnt/rvalid bus, aligns and extends load data, and hands a writeback packet to the writeback stage. While an access is outstanding it requests an upstream stall; non-memory instructions pass through with no extra latency.

## Interface
- TIMEOUT_CYCLES, 255: maximum number of WAIT cycles before a bus error is declared (1..255).
- clk  in  1  pipeline clock.
- rst  in  1  reset, asynchronous, active-high.
- stall_i  in  1  global/downstream stall; holds the pipeline register and DONE result.
- ex2mem_i  in  ex2memPkt  execute-stage packet: pc, inst32, instValid, aux, destReg, res (effective address or ALU result), memOp, storeData.
- stall_o  out  1  high while the resident instruction's memory access is not complete.
- dmem_req  out  1  access request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  32  word-aligned address ({res[31:2],2'b00}).
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_gnt  in  1  request accepted this cycle.
- dmem_rvalid  in  1  response (loads and stores), never earlier than the cycle after gnt.
- dmem_rdata  in  32  load data, valid with rvalid.
- misalign_o  out  1  resident instruction is a misaligned access.
- mem2wb_o  out  mem2wbPkt  pc, inst32, instValid, destReg, wbData, err.

## Operation
- Pipeline register loads ex2mem_i when !stall_i && !stall_o; otherwise holds. Reset value all-zero (instValid=0).
- memAccess = instValid && memOp != MEM_NONE. Misaligned: halfword ops with res[0]=1, word ops with res[1:0]!=0.
- FSM: IDLE, WAIT, DONE.
  - IDLE: if memAccess && aligned, dmem_req=1 (addr/be/we/wdata from register); gnt -> WAIT. Else stays IDLE.
  - WAIT: req=0, counter increments; rvalid -> DONE (rdata latched); counter reaching TIMEOUT_CYCLES -> DONE with err=ERR_BUS.
  - DONE: result held; leaves to IDLE when the register advances (!stall_i).
- stall_o = memAccess && aligned && state != DONE.
- Stores: SB be=1<<res[1:0], wdata={4{storeData[7:0]}}; SH be=res[1]?4'b1100:4'b0011, wdata={2{storeData[15:0]}}; SW be=4'b1111.
- Loads: LB/LH sign-extend, LBU/LHU zero-extend selected lane; LW full word.
- Output: if stall_o, bubble (instValid=0, destReg=0). Else instValid passes; wbData = load data for loads, res for non-memory ops; destReg forced 0 for stores, misaligned ops and bus errors. err: ERR_NONE / ERR_MISALIGN / ERR_BUS.
- Misaligned: no bus request, no stall, misalign_o=1 while resident.
- rvalid/gnt ignored in IDLE and DONE.

## Timing
- Reset: state IDLE, counter 0, dmem_req=0, stall_o=0, misalign_o=0, mem2wb_o all-zero; dmem_req drops immediately on rst assertion.
- Non-memory op: visible on mem2wb_o the cycle after capture.
- Load/store, gnt same cycle, rvalid next: captured at edge N; req+gnt cycle N; rvalid N+1; DONE N+2 with stall_o low and valid output; advances end of N+2.
- Delayed gnt: request and payload held stable until gnt.
- stall_i in DONE: output held, exactly one valid writeback delivered.
- Reset mid-access: abandons access; late rvalid after reset ignored.

## Structure
- Shared package (akarin.svh): memOp_t enum (MEM_NONE, LB, LH, LW, LBU, LHU, SB, SH, SW), memOp/storeData fields in ex2memPkt, mem2wbPkt, errCode_t, memState_t.
- Sub-module mem_load_align: combinational lane select and sign/zero extension.

## Test plan
- SW res=0x100, storeData=0xDEADBEEF, gnt immediate, rvalid next -> be=4'b1111, wdata=0xDEADBEEF, stall_o high 2 cycles, one output with destReg=0, err=ERR_NONE.
- LB res=0x103, rdata=0x80123456 -> wbData=0xFFFFFF80; LBU same -> 0x00000080; LH res=0x102 -> 0xFFFF8012.
- LH res=0x101 -> no dmem_req, misalign_o=1, stall_o=0, destReg=0, err=ERR_MISALIGN.
- LW with gnt delayed 3 cycles, then stall_i high 2 cycles in DONE -> req/addr stable until gnt, output held, single writeback of rdata.
- TIMEOUT_CYCLES=4, no rvalid -> DONE after 4 WAIT cycles, err=ERR_BUS, destReg=0, stall_o drops.
- rst asserted in WAIT, rvalid arrives next cycle -> dmem_req=0, outputs zero, state IDLE, rvalid ignored; subsequent ADD result 0x5 passes with one-cycle latency.
